// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter and busy scoreboard in front of the register file write port.
//
// Two requesters (ALU and LSU) share a single register file write port. A round-robin arbiter
// grants at most one of them per cycle, and the accepted write appears on rf_* one cycle later.
// Writes to x0 are consumed but never reach the register file, because the file itself has no
// x0 protection. A busy bit per register tracks outstanding writes so issue can stall on
// RAW/WAW hazards.
//
// Ports:
//   clk, rst                                  clock, asynchronous active-high reset
//   alu_valid/alu_ready/alu_dest/alu_data     ALU writeback request (valid/ready handshake)
//   lsu_valid/lsu_ready/lsu_dest/lsu_data     LSU writeback request (valid/ready handshake)
//   issue_valid/issue_has_dest/issue_dest     issuing instruction and its destination
//   issue_rs1/issue_rs2                       issuing instruction's source operands
//   issue_stall                               issue must hold this cycle
//   rf_rw/rf_dest/rf_write_data               registered register file write port
//   busy                                      scoreboard vector (debug/trace)
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDR_W-1:0]   alu_dest,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [ADDR_W-1:0]   lsu_dest,
  input  logic [DATA_W-1:0]   lsu_data,
  input  logic                issue_valid,
  input  logic                issue_has_dest,
  input  logic [ADDR_W-1:0]   issue_dest,
  input  logic [ADDR_W-1:0]   issue_rs1,
  input  logic [ADDR_W-1:0]   issue_rs2,
  output logic                issue_stall,
  output logic                rf_rw,
  output logic [ADDR_W-1:0]   rf_dest,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic [NUM_REGS-1:0] busy
);

  typedef enum logic {SrcAlu, SrcLsu} src_e;

  src_e                rr_last_q;
  logic                rf_rw_q;
  logic [ADDR_W-1:0]   rf_dest_q;
  logic [DATA_W-1:0]   rf_data_q;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic                alu_grant, lsu_grant, accept;
  logic [ADDR_W-1:0]   sel_dest;
  logic [DATA_W-1:0]   sel_data;
  logic                set_en;

  // Grants are gated by rst so nothing is handshaken while the block is held in reset.
  always_comb begin
    alu_grant = !rst && alu_valid && (!lsu_valid || (rr_last_q == SrcLsu));
    lsu_grant = !rst && lsu_valid && (!alu_valid || (rr_last_q == SrcAlu));
    accept    = alu_grant || lsu_grant;
    sel_dest  = alu_grant ? alu_dest : lsu_dest;
    sel_data  = alu_grant ? alu_data : lsu_data;
  end

  assign alu_ready = alu_grant;
  assign lsu_ready = lsu_grant;

  // No bypass: a register being written this cycle still reads as busy.
  always_comb begin
    issue_stall = issue_valid && (busy_q[issue_rs1] || busy_q[issue_rs2] ||
                                  (issue_has_dest && busy_q[issue_dest]));
    set_en      = issue_valid && !issue_stall && issue_has_dest && (issue_dest != '0);
  end

  // Clear first, then set, so a same-index set overrides the commit clear.
  always_comb begin
    busy_d = busy_q;
    if (rf_rw_q) begin
      busy_d[rf_dest_q] = 1'b0;
    end
    if (set_en) begin
      busy_d[issue_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q <= SrcLsu;
      rf_rw_q   <= 1'b0;
      rf_dest_q <= '0;
      rf_data_q <= '0;
      busy_q    <= '0;
    end else begin
      busy_q  <= busy_d;
      rf_rw_q <= accept && (sel_dest != '0);
      if (accept) begin
        rr_last_q <= alu_grant ? SrcAlu : SrcLsu;
        rf_dest_q <= sel_dest;
        rf_data_q <= sel_data;
      end
    end
  end

  assign rf_rw         = rf_rw_q;
  assign rf_dest       = rf_dest_q;
  assign rf_write_data = rf_data_q;
  assign busy          = busy_q;

endmodule
